// File: rtl/noc_params.sv
// Shared link parameters and types for the credit-based transmit path.
package noc_params;
  localparam int VC_NUM      = 2;
  localparam int BUFFER_SIZE = 8;
  localparam int FLIT_SIZE   = 8;
  localparam int VC_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CNT_W       = $clog2(BUFFER_SIZE + 1);

  typedef logic [FLIT_SIZE-1:0] flit_t;
  typedef logic [VC_W-1:0]      vc_id_t;
  typedef logic [CNT_W-1:0]     cnt_t;
endpackage

// File: rtl/credit_counter.sv
// One VC's credit counter: saturates at both ends and flags returns beyond the buffer depth.
module credit_counter
  import noc_params::*;
(
  input  logic clk,
  input  logic rst,
  input  logic dec_i,
  input  logic inc_i,
  output logic avail_o,
  output logic overflow_o
);

  localparam cnt_t CNT_MAX = cnt_t'(BUFFER_SIZE);

  cnt_t cnt;
  cnt_t cnt_nxt;

  always_comb begin
    cnt_nxt    = cnt;
    overflow_o = 1'b0;
    if (dec_i && !inc_i) begin
      if (cnt != '0) cnt_nxt = cnt - cnt_t'(1);
    end else if (inc_i && !dec_i) begin
      if (cnt == CNT_MAX) overflow_o = 1'b1;
      else                cnt_nxt    = cnt + cnt_t'(1);
    end
  end

  // avail_o tracks the next count so it never lags the counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= CNT_MAX;
      avail_o <= 1'b1;
    end else begin
      cnt     <= cnt_nxt;
      avail_o <= (cnt_nxt != '0);
    end
  end

endmodule

// File: rtl/credit_flow_tx.sv
// Transmit end of a credit-based link: gates switch flits on per-VC credits and registers them onto the link.
module credit_flow_tx
  import noc_params::*;
(
  input  logic              clk,
  input  logic              rst,
  input  flit_t             flit_i,
  input  logic              valid_i,
  input  vc_id_t            vc_id_i,
  output logic              ready_o,
  input  logic [VC_NUM-1:0] credit_i,
  output flit_t             flit_o,
  output logic              valid_o,
  output vc_id_t            vc_id_o,
  output logic [VC_NUM-1:0] credit_avail_o,
  output logic              error_o
);

  logic              send;
  logic [VC_NUM-1:0] dec;
  logic [VC_NUM-1:0] overflow;

  assign ready_o = credit_avail_o[vc_id_i];
  assign send    = valid_i & ready_o;

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    assign dec[g] = send & (vc_id_i == vc_id_t'(g));

    credit_counter u_cnt (
      .clk        (clk),
      .rst        (rst),
      .dec_i      (dec[g]),
      .inc_i      (credit_i[g]),
      .avail_o    (credit_avail_o[g]),
      .overflow_o (overflow[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_o  <= '0;
      valid_o <= 1'b0;
      vc_id_o <= '0;
      error_o <= 1'b0;
    end else begin
      valid_o <= send;
      if (send) begin
        flit_o  <= flit_i;
        vc_id_o <= vc_id_i;
      end
      error_o <= error_o | (|overflow);
    end
  end

endmodule

// File: tb/tb_credit_flow_tx.sv
// Randomized and directed checks of credit_flow_tx against a credit-arithmetic model.
module tb_credit_flow_tx;
  import noc_params::*;

  logic              clk;
  logic              rst;
  flit_t             flit_i;
  logic              valid_i;
  vc_id_t            vc_id_i;
  logic              ready_o;
  logic [VC_NUM-1:0] credit_i;
  flit_t             flit_o;
  logic              valid_o;
  vc_id_t            vc_id_o;
  logic [VC_NUM-1:0] credit_avail_o;
  logic              error_o;

  credit_flow_tx dut (
    .clk(clk), .rst(rst), .flit_i(flit_i), .valid_i(valid_i), .vc_id_i(vc_id_i),
    .ready_o(ready_o), .credit_i(credit_i), .flit_o(flit_o), .valid_o(valid_o),
    .vc_id_o(vc_id_o), .credit_avail_o(credit_avail_o), .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model state
  int    m_cnt [VC_NUM];
  bit    m_err;
  bit    m_valid;
  int    m_flit;
  int    m_vc;
  int    obs_sends;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < VC_NUM; v++) m_cnt[v] = BUFFER_SIZE;
    m_err = 0; m_valid = 0; m_flit = 0; m_vc = 0;
  endtask

  task automatic check_outputs();
    int avail;
    avail = 0;
    for (int v = 0; v < VC_NUM; v++) if (m_cnt[v] != 0) avail |= (1 << v);
    chk("valid_o", int'(valid_o), int'(m_valid));
    chk("flit_o", int'(flit_o), m_flit);
    chk("vc_id_o", int'(vc_id_o), m_vc);
    chk("credit_avail_o", int'(credit_avail_o), avail);
    chk("error_o", int'(error_o), int'(m_err));
    if (valid_o) obs_sends++;
  endtask

  // one clock: drive, check ready, advance model at the edge, check registered outputs
  task automatic cycle(input bit v, input int vc, input int f, input int cr);
    bit send;
    valid_i  = v;
    vc_id_i  = vc_id_t'(vc);
    flit_i   = flit_t'(f);
    credit_i = VC_NUM'(cr);
    #1;
    chk("ready_o", int'(ready_o), int'(m_cnt[vc] != 0));
    send = v && (m_cnt[vc] != 0);
    @(posedge clk);
    for (int k = 0; k < VC_NUM; k++) begin
      bit inc, dec;
      inc = cr[k];
      dec = send && (vc == k);
      if (dec && !inc) m_cnt[k] = m_cnt[k] - 1;
      else if (inc && !dec) begin
        if (m_cnt[k] == BUFFER_SIZE) m_err = 1;
        else m_cnt[k] = m_cnt[k] + 1;
      end
    end
    m_valid = send;
    if (send) begin m_flit = f & 8'hFF; m_vc = vc; end
    #1;
    check_outputs();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    valid_i = 0; credit_i = '0; flit_i = '0; vc_id_i = '0;
    rst = 1;
    model_reset();
    #2;
    chk("reset_avail", int'(credit_avail_o), (1 << VC_NUM) - 1);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_error", int'(error_o), 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  // offer flits on one VC for 10 cycles; returns how many went out
  task automatic drain(input int vc, output int n);
    int start;
    start = obs_sends;
    for (int i = 0; i < 10; i++) cycle(1, vc, $urandom_range(255), 0);
    n = obs_sends - start;
  endtask

  initial begin
    int n, s0;
    rst = 0; valid_i = 0; credit_i = '0; flit_i = '0; vc_id_i = '0;
    obs_sends = 0;
    model_reset();
    #2 rst = 1;
    #1;
    chk("async_reset_valid", int'(valid_o), 0);
    reset_dut();

    // 1: exhaust vc0
    drain(0, n);
    chk("t1_sends", n, 8);
    chk("t1_avail0", int'(credit_avail_o[0]), 0);

    // 2: single credit return at zero
    cycle(0, 0, 0, 1);
    vc_id_i = '0; #1;
    chk("t2_ready_after_credit", int'(ready_o), 1);
    s0 = obs_sends;
    cycle(1, 0, 8'h55, 0);
    chk("t2_one_flit", obs_sends - s0, 1);
    chk("t2_flit", int'(flit_o), 8'h55);
    chk("t2_ready_low", int'(ready_o), 0);

    // 3: send+credit on same VC keeps count
    reset_dut();
    for (int i = 0; i < 3; i++) cycle(1, 1, i, 0);
    s0 = obs_sends;
    for (int i = 0; i < 3; i++) cycle(1, 1, 8'h30 + i, 2);
    chk("t3_flits", obs_sends - s0, 3);
    chk("t3_error", int'(error_o), 0);
    drain(1, n);
    chk("t3_remaining", n, 5);

    // 4: overflow is sticky and does not raise the count
    reset_dut();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);
    chk("t4_error_sticky", int'(error_o), 1);
    drain(0, n);
    chk("t4_sends", n, 8);

    // 5: alternating VCs
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      cycle(1, i % 2, 8'hA0 + i, 0);
      chk("t5_flit", int'(flit_o), 8'hA0 + i);
      chk("t5_vc", int'(vc_id_o), i % 2);
    end
    drain(0, n);
    chk("t5_vc0_left", n, 4);
    drain(1, n);
    chk("t5_vc1_left", n, 4);

    // 6: async reset mid-stream
    reset_dut();
    cycle(0, 0, 0, 1);
    cycle(1, 1, 8'h77, 0);
    chk("t6_valid_before", int'(valid_o), 1);
    #2 rst = 1;
    #1;
    chk("t6_valid_async", int'(valid_o), 0);
    chk("t6_error_async", int'(error_o), 0);
    chk("t6_avail_async", int'(credit_avail_o), 3);
    chk("t6_flit_async", int'(flit_o), 0);
    reset_dut();
    drain(1, n);
    chk("t6_vc1_full", n, 8);

    // random traffic
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      int cr;
      cr = 0;
      for (int k = 0; k < VC_NUM; k++) if ($urandom_range(3) == 0) cr |= (1 << k);
      cycle($urandom_range(1), $urandom_range(VC_NUM - 1), $urandom_range(255), cr);
      if (i == 300) reset_dut();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
